// File: rtl/csa64_op_sequencer_pkg.sv
// Shared definitions for the 64-bit carry-select adder feeder.
//   WORD_W          adder operand/sum width
//   seq_state_t     sequencer FSM encoding
//   beats_per_op()  number of input beats that make up one operand
package csa64_op_sequencer_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic int beats_per_op(input int in_w);
        return WORD_W / in_w;
    endfunction

endpackage

// File: rtl/csa64_op_packer.sv
// Operand packer: counts accepted beats and inserts each one into its slot
// of the two operand registers, least significant slot first, op1 then op2.
//   clock, reset   system clock, synchronous active-high reset
//   clear          abort: rewind the beat counter, keep operand contents
//   beat_en        a beat transfers this cycle
//   in_data        beat payload
//   op1, op2       assembled operands (registered)
//   last_beat      the next transfer completes op2
module csa64_op_packer
    import csa64_op_sequencer_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              beat_en,
    input  logic [IN_W-1:0]   in_data,
    output logic [WORD_W-1:0] op1,
    output logic [WORD_W-1:0] op2,
    output logic              last_beat
);

    localparam int BEATS = beats_per_op(IN_W);
    localparam int TOT   = 2 * BEATS;
    localparam int CW    = $clog2(TOT);

    logic [CW-1:0]                    beat_cnt;
    // [operand][slot][bit]: slot 0 is the least significant IN_W bits
    logic [1:0][BEATS-1:0][IN_W-1:0]  ops;

    assign op1       = ops[0];
    assign op2       = ops[1];
    assign last_beat = (beat_cnt == CW'(TOT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            beat_cnt <= '0;
            ops      <= '0;
        end else if (clear) begin
            // aborted transaction: operand registers keep their contents
            beat_cnt <= '0;
        end else if (beat_en) begin
            for (int b = 0; b < TOT; b++) begin
                if (beat_cnt == CW'(b))
                    ops[b / BEATS][b % BEATS] <= in_data;
            end
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/csa64_op_sequencer.sv
// Feeder and result collector for the registered 64-bit carry-select adder.
// Collects two operands from a beat stream, holds them on the adder for
// LATENCY cycles, captures sum/carry-out and offers them on an output
// handshake. One transaction in flight at a time.
//   clock, reset           system clock, synchronous active-high reset
//   flush                  abort current transaction (below reset priority)
//   in_valid/in_ready      input beat handshake, in_data beat payload
//   add_op1/add_op2        operands to the adder (registered)
//   add_sum/add_crout      adder results
//   out_valid/out_ready    result handshake, out_sum/out_crout payload
//   busy                   high while waiting on the adder or holding a result
//   done_count             completed transactions, wraps
module csa64_op_sequencer
    import csa64_op_sequencer_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic [WORD_W-1:0] add_op1,
    output logic [WORD_W-1:0] add_op2,
    input  logic [WORD_W-1:0] add_sum,
    input  logic              add_crout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_crout,
    output logic              busy,
    output logic [CNT_W-1:0]  done_count
);

    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    seq_state_t state;
    logic [3:0] lat_cnt;
    logic       last_beat;
    logic       beat_fire;

    // in_ready is registered and only high in LOAD, so it gates acceptance
    assign beat_fire = in_valid && in_ready;

    csa64_op_packer #(.IN_W(IN_W)) u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .beat_en   (beat_fire),
        .in_data   (in_data),
        .op1       (add_op1),
        .op2       (add_op2),
        .last_beat (last_beat)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= LOAD;
            lat_cnt    <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_sum    <= '0;
            out_crout  <= 1'b0;
            done_count <= '0;
        end else if (flush) begin
            state     <= LOAD;
            lat_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (beat_fire && last_beat) begin
                        state    <= WAIT;
                        lat_cnt  <= LAT_INIT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    // lat_cnt == 0 marks the first cycle the adder output
                    // reflects the operands launched at WAIT entry
                    if (lat_cnt == 4'd0) begin
                        out_sum   <= add_sum;
                        out_crout <= add_crout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state      <= LOAD;
                        out_valid  <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b0;
                        done_count <= done_count + 1'b1;
                    end
                end
                default: begin
                    state     <= LOAD;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa64_op_sequencer.sv
// Bench for csa64_op_sequencer: instance 0 uses the default build
// (LATENCY=2, CNT_W=16) with a one-register adder model, instance 1 uses
// LATENCY=1, CNT_W=4 with a combinational adder model.
module tb_csa64_op_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]        reset, flush, in_valid, out_ready;
    logic [1:0][15:0]  in_data;
    wire  [1:0]        in_ready, out_valid, busy, out_crout, add_crout;
    wire  [1:0][63:0]  add_op1, add_op2, add_sum, out_sum;
    wire  [15:0]       dc0;
    wire  [3:0]        dc1;

    // adder models: instance 0 has one result register, instance 1 none
    logic [64:0] sum_r0;
    wire  [64:0] sum_c1 = {1'b0, add_op1[1]} + {1'b0, add_op2[1]};
    always @(posedge clock) sum_r0 <= {1'b0, add_op1[0]} + {1'b0, add_op2[0]};
    assign add_sum[0]   = sum_r0[63:0];
    assign add_crout[0] = sum_r0[64];
    assign add_sum[1]   = sum_c1[63:0];
    assign add_crout[1] = sum_c1[64];

    csa64_op_sequencer #(.IN_W(16), .LATENCY(2), .CNT_W(16)) u_dut0 (
        .clock(clock), .reset(reset[0]), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .add_op1(add_op1[0]), .add_op2(add_op2[0]),
        .add_sum(add_sum[0]), .add_crout(add_crout[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_crout(out_crout[0]),
        .busy(busy[0]), .done_count(dc0)
    );

    csa64_op_sequencer #(.IN_W(16), .LATENCY(1), .CNT_W(4)) u_dut1 (
        .clock(clock), .reset(reset[1]), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .add_op1(add_op1[1]), .add_op2(add_op2[1]),
        .add_sum(add_sum[1]), .add_crout(add_crout[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_crout(out_crout[1]),
        .busy(busy[1]), .done_count(dc1)
    );

    int vecs = 0;
    int errs = 0;
    int unsigned mcount [2];

    typedef struct {
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] sum;
        logic        crout;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dcount(input int d);
        return (d == 0) ? 64'(dc0) : 64'(dc1);
    endfunction

    function automatic logic [63:0] mcount_exp(input int d);
        return (d == 0) ? 64'(mcount[0] % 65536) : 64'(mcount[1] % 16);
    endfunction

    // caller is at a negedge; returns at the negedge after the transfer edge
    task automatic send_beat(input int d, input logic [15:0] data, input int gap_max);
        int n;
        int gap;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int i = 0; i < gap; i++) begin
            in_valid[d] = 1'b0;
            in_data[d]  = 16'($urandom);
            @(negedge clock);
        end
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        n = 0;
        while (!in_ready[d] && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("beat_accept_timeout", 64'(in_ready[d]), 64'd1);
        @(negedge clock);
        in_valid[d] = 1'b0;
        in_data[d]  = 16'($urandom);
    endtask

    task automatic send_ops(input int d, input logic [63:0] op1, input logic [63:0] op2,
                            input int gap_max);
        for (int b = 0; b < 8; b++)
            send_beat(d, (b < 4) ? op1[b*16 +: 16] : op2[(b-4)*16 +: 16], gap_max);
    endtask

    // full transaction with expected result supplied by the caller
    task automatic run_txn(input int d, input logic [63:0] op1, input logic [63:0] op2,
                           input logic [63:0] esum, input logic ecr,
                           input int gap_max, input int hold);
        int n;
        out_ready[d] = 1'b0;
        send_ops(d, op1, op2, gap_max);
        n = 1;
        while (!out_valid[d] && n < 40) begin
            chk("wait_in_ready", 64'(in_ready[d]), 64'd0);
            chk("wait_busy", 64'(busy[d]), 64'd1);
            chk("wait_op1", add_op1[d], op1);
            chk("wait_op2", add_op2[d], op2);
            @(negedge clock);
            n++;
        end
        chk("latency", 64'(n), (d == 0) ? 64'd3 : 64'd2);
        chk("sum", out_sum[d], esum);
        chk("crout", 64'(out_crout[d]), 64'(ecr));
        for (int i = 0; i < hold; i++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 16'($urandom);
            @(negedge clock);
            chk("hold_valid", 64'(out_valid[d]), 64'd1);
            chk("hold_sum", out_sum[d], esum);
            chk("hold_crout", 64'(out_crout[d]), 64'(ecr));
            chk("hold_in_ready", 64'(in_ready[d]), 64'd0);
            chk("hold_busy", 64'(busy[d]), 64'd1);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clock);
        out_ready[d] = 1'b0;
        mcount[d]++;
        chk("post_valid", 64'(out_valid[d]), 64'd0);
        chk("post_in_ready", 64'(in_ready[d]), 64'd1);
        chk("post_busy", 64'(busy[d]), 64'd0);
        chk("done_count", dcount(d), mcount_exp(d));
        chk("post_op1", add_op1[d], op1);
        chk("post_op2", add_op2[d], op2);
    endtask

    task automatic run_rand(input int d, input int gap_max, input int hold_max);
        logic [63:0] a, b;
        logic [64:0] s;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        s = 65'(a) + 65'(b);
        run_txn(d, a, b, s[63:0], s[64], gap_max, int'($urandom_range(hold_max, 0)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    vec_t tbl [6];

    initial begin
        logic [63:0] j1, j2;
        tbl[0] = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0};
        tbl[1] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 64'h1234_5678_9ABC_DF00, 1'b0, 10};
        tbl[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 2};
        tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b0, 1};
        tbl[4] = '{64'h0, 64'h0, 64'h0, 1'b0, 0};
        tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 3};

        reset = 2'b11; flush = '0; in_valid = '0; out_ready = '0; in_data = '0;
        mcount[0] = 0; mcount[1] = 0;
        repeat (3) @(negedge clock);
        reset = 2'b00;

        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 64'(in_ready[d]), 64'd1);
            chk("rst_op1", add_op1[d], 64'd0);
            chk("rst_op2", add_op2[d], 64'd0);
            chk("rst_sum", out_sum[d], 64'd0);
            chk("rst_crout", 64'(out_crout[d]), 64'd0);
            chk("rst_valid", 64'(out_valid[d]), 64'd0);
            chk("rst_busy", 64'(busy[d]), 64'd0);
            chk("rst_count", dcount(d), 64'd0);
        end

        // directed vectors
        for (int i = 0; i < 6; i++)
            run_txn(0, tbl[i].op1, tbl[i].op2, tbl[i].sum, tbl[i].crout, 0, tbl[i].hold);

        // flush after 5 beats; a beat presented with flush is dropped
        j1 = 64'hDEAD_BEEF_CAFE_F00D;
        j2 = 64'h0000_0000_0000_5A5A;
        for (int b = 0; b < 5; b++)
            send_beat(0, (b < 4) ? j1[b*16 +: 16] : j2[15:0], 0);
        flush[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 16'h7777;
        @(negedge clock);
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        chk("flush_in_ready", 64'(in_ready[0]), 64'd1);
        chk("flush_busy", 64'(busy[0]), 64'd0);
        chk("flush_count", dcount(0), mcount_exp(0));
        chk("flush_keep_op1", add_op1[0], j1);
        run_txn(0, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 64'h7, 1'b0, 0, 0);

        // flush while waiting on the adder: no result, no count
        send_ops(0, 64'h1, 64'h2, 0);
        flush[0] = 1'b1;
        @(negedge clock);
        flush[0] = 1'b0;
        chk("flushw_in_ready", 64'(in_ready[0]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("flushw_no_valid", 64'(out_valid[0]), 64'd0);
            @(negedge clock);
        end
        chk("flushw_count", dcount(0), mcount_exp(0));

        // reset while waiting on the adder
        send_ops(0, 64'h1234, 64'h5678, 0);
        reset[0] = 1'b1;
        @(negedge clock);
        reset[0] = 1'b0;
        mcount[0] = 0;
        chk("rstw_in_ready", 64'(in_ready[0]), 64'd1);
        chk("rstw_op1", add_op1[0], 64'd0);
        chk("rstw_op2", add_op2[0], 64'd0);
        chk("rstw_sum", out_sum[0], 64'd0);
        chk("rstw_busy", 64'(busy[0]), 64'd0);
        chk("rstw_count", dcount(0), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rstw_no_valid", 64'(out_valid[0]), 64'd0);
            @(negedge clock);
        end

        // randomized transactions with gappy input and random backpressure
        for (int i = 0; i < 40; i++) run_rand(0, 3, 4);

        // LATENCY=1 build; 17 transactions wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) run_rand(1, 2, 2);
        chk("wrap_count", 64'(dc1), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/csa64_op_sequencer.md
Name: csa64_op_sequencer

Overview:
Upstream feeder and result collector for the team's registered 64-bit carry-select adder stage (operands registered on one edge, sum/carry registered on the next, carry-in fixed at 0).
- Assembles two 64-bit operands from a 16-bit handshaked input stream.
- Presents the operands to the adder, waits the adder's fixed latency, then captures sum and carry-out.
- Returns the result on a valid/ready output handshake, one transaction at a time.

Parameters:
IN_W, 16, input beat width; must divide 64; beats per operand = 64/IN_W.
LATENCY, 2, cycles from first cycle operands are driven to the cycle the adder sum/crout are sampled; legal range 1..15.
CNT_W, 16, width of the completed-transaction counter.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous abort of the current transaction.
in_valid  input  1  input beat valid.
in_ready  output  1  sequencer accepts a beat.
in_data  input  IN_W  operand beat.
add_op1  output  64  operand 1 to the adder (registered).
add_op2  output  64  operand 2 to the adder (registered).
add_sum  input  64  adder sum output.
add_crout  input  1  adder carry-out.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_sum  output  64  captured sum.
out_crout  output  1  captured carry-out.
busy  output  1  high in WAIT or DONE.
done_count  output  CNT_W  completed transactions; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset are fixed: one clock; reset is synchronous and active-high.
- Reset value of every output:
  - in_ready = 1.
  - add_op1, add_op2, out_sum = 0.
  - out_crout, out_valid, busy = 0.
  - done_count = 0.
  - State = LOAD, beat count = 0.
- State machine: LOAD -> WAIT -> DONE -> LOAD.
- LOAD:
  - in_ready = 1; a beat transfers when in_valid && in_ready.
  - Beats 0..3 fill add_op1[16k+15:16k], least significant first; beats 4..7 fill add_op2 the same way (generalised via IN_W).
  - On the last beat transfer: go to WAIT, load the wait counter with LATENCY-1.
  - No beat is accepted outside LOAD.
- Operand stability:
  - add_op1 and add_op2 change only on beat transfers in LOAD.
  - They are stable from the first WAIT cycle through DONE.
- WAIT:
  - Counter decrements each cycle; in_ready = 0.
  - When the counter is 0: sample add_sum into out_sum and add_crout into out_crout, then go to DONE.
  - With LATENCY=2, sampling occurs at the end of the second WAIT cycle. This is the first cycle in which the adder's registered sum reflects the operands, given they were stable before the adder's operand-capture edge.
- DONE:
  - out_valid = 1; out_sum and out_crout hold.
  - On out_valid && out_ready: go to LOAD, out_valid drops, done_count increments.
  - in_ready rises the cycle after the handshake; there is no same-cycle bypass.
- Backpressure: out_ready low holds DONE indefinitely; outputs stay unchanged.
- busy = (state == WAIT) || (state == DONE).
- flush:
  - Priority is below reset and above all other events.
  - Effect: state = LOAD, beat count = 0, out_valid = 0, in_ready = 1 next cycle.
  - No done_count increment; any beat presented in the same cycle is dropped.
  - add_op1, add_op2 and out_sum keep their values.
- Reset mid-operation: all state returns to reset values on that edge; partial operands are discarded.
- in_valid is ignored when in_ready = 0; in_data is don't-care when in_valid = 0.

Decomposition:
- Shared package:
  - State encoding LOAD=2'd0, WAIT=2'd1, DONE=2'd2.
  - Constant WORD_W = 64.
  - Derived BEATS_PER_OP = WORD_W/IN_W.
- One natural sub-module, csa64_op_packer: beat counter plus shift/insert into the two operand registers, with a last_beat flag.
- FSM, latency counter and result capture stay in the top.

Test Plan:
- Reset, then beats 0001,0000,0000,0000,FFFF,FFFF,FFFF,FFFF with the adder model attached -> out_sum = 0, out_crout = 1, out_valid exactly 3 cycles after the last beat, done_count = 1.
- op1 = 0123456789ABCDEF, op2 = 1111111111111111 -> out_sum = 123456789ABCDF00, out_crout = 0; add_op1 and add_op2 stable throughout WAIT/DONE.
- out_ready held low for 10 cycles in DONE -> out_valid, out_sum and out_crout constant, in_ready = 0 and no beat accepted; release -> in_ready = 1 on the next cycle.
- flush after 5 beats -> next 8 beats form a fresh transaction; its result is correct and done_count increments by 1 only.
- reset asserted in WAIT -> all outputs at reset values next cycle, no out_valid pulse; LATENCY=1 build -> sampling on the first WAIT cycle, result matches the zero-latency adder model.
- 65537 back-to-back transactions with CNT_W=16 -> done_count wraps to 1; in_valid toggling randomly yields correct beat ordering.
